// File: rtl/apb_rr_master_arb.sv
// Round-robin arbiter that lets NUM_REQ requesters share one APB master port.
// One transfer outstanding at a time: IDLE handshake, SETUP, ACCESS (with timeout), RESP.
module apb_rr_master_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  input  logic                      pready,
  input  logic [DATA_W-1:0]         prdata
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_grant;
  logic [IDX_W-1:0]    grant_q;
  logic [IDX_W-1:0]    winner;
  logic                any_valid;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                timeout_hit;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // First valid requester searching upward from the one after last_grant.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!any_valid && req_valid[IDX_W'((32'(last_grant) + k) % NUM_REQ)]) begin
        any_valid = 1'b1;
        winner    = IDX_W'((32'(last_grant) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, round-robin pointer, wait counter and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
      grant_q    <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            addr_q     <= req_addr[32'(winner)*ADDR_W +: ADDR_W];
            write_q    <= req_write[winner];
            wdata_q    <= req_wdata[32'(winner)*DATA_W +: DATA_W];
            grant_q    <= winner;
            last_grant <= winner;
          end
        end
        SETUP: cnt_q <= '0;
        ACCESS: begin
          if (pready) begin
            rdata_q <= write_q ? '0 : prdata;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake is only offered in IDLE; suppressed while reset is held.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && any_valid && !reset) req_ready[winner] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[grant_q] = 1'b1;
  end

  assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;
  assign rsp_err   = (state_q == RESP) && err_q;
  assign psel      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable   = (state_q == ACCESS);
  assign paddr     = addr_q;
  assign pwrite    = write_q;
  assign pwdata    = wdata_q;

endmodule

// File: tb/tb_apb_rr_master_arb.sv
// Directed bench for apb_rr_master_arb with a small APB memory slave model.
module tb_apb_rr_master_arb;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_write = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      psel, penable, pwrite, pready;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata, prdata;

  int vectors = 0;
  int errors  = 0;

  // Slave model: memory returning 0xcacacaca for unwritten locations.
  logic [31:0] mem [256];
  logic        written [256];
  int          acc_cnt = 0;
  int          wait_states = 0;
  logic        slave_en = 1'b1;

  assign prdata = written[paddr] ? mem[paddr] : 32'hcacacaca;
  assign pready = slave_en && psel && penable && (acc_cnt >= wait_states);

  always @(posedge clk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (psel && penable && pready && pwrite) begin
      mem[paddr]     <= pwdata;
      written[paddr] <= 1'b1;
    end
  end

  always #5 clk = ~clk;

  apb_rr_master_arb #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  task automatic set_cmd(input int i, input logic w, input logic [7:0] a, input logic [31:0] d);
    req_write[i]          = w;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  // Raise valid, wait for the handshake, drop valid; returns at the SETUP-cycle negedge.
  task automatic issue(input int i, input logic w, input logic [7:0] a, input logic [31:0] d);
    bit done = 0;
    set_cmd(i, w, a, d);
    req_valid[i] = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      #1;
      if (req_ready[i]) done = 1;
      @(negedge clk);
    end
    req_valid[i] = 1'b0;
    vectors++;
    if (!done) begin
      errors++;
      $display("FAIL issue_handshake req%0d got no req_ready, want handshake", i);
    end
  endtask

  task automatic wait_rsp(output logic [3:0] v, output logic [31:0] d, output logic e, output int n);
    v = '0; d = '0; e = 1'b0; n = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        v = rsp_valid; d = rsp_rdata; e = rsp_err; n = c;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({psel, penable, pwrite, rsp_err, req_ready, rsp_valid} !== '0 || paddr !== '0 ||
        pwdata !== '0 || rsp_rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs got psel=%b pen=%b rdy=%b rv=%b addr=%h, want all 0",
               psel, penable, req_ready, rsp_valid, paddr);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    set_cmd(0, 1'b1, 8'h10, 32'h12345678);
    req_valid[0] = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL wr_ready got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid[0] = 1'b0;
    vectors++;
    if ({psel, penable} !== 2'b10) begin errors++; $display("FAIL wr_setup got %b want 10", {psel, penable}); end
    @(negedge clk);
    vectors++;
    if ({psel, penable, pwrite} !== 3'b111 || paddr !== 8'h10 || pwdata !== 32'h12345678 || rsp_valid !== '0) begin
      errors++;
      $display("FAIL wr_access got sel/en/wr=%b addr=%h wdata=%h rv=%b want 111 10 12345678 0000",
               {psel, penable, pwrite}, paddr, pwdata, rsp_valid);
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0 || rsp_rdata !== '0 || psel !== 1'b0) begin
      errors++;
      $display("FAIL wr_resp got rv=%b err=%b rdata=%h psel=%b want 0001 0 0 0", rsp_valid, rsp_err, rsp_rdata, psel);
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== '0 || psel !== 1'b0) begin errors++; $display("FAIL wr_idle got rv=%b psel=%b want 0000 0", rsp_valid, psel); end
  endtask

  task automatic test_read_after_write();
    logic [3:0] v; logic [31:0] d; logic e; int n;
    issue(2, 1'b0, 8'h10, 32'h0);
    wait_rsp(v, d, e, n);
    vectors++;
    if (v !== 4'b0100 || d !== 32'h12345678 || e !== 1'b0 || n !== 2) begin
      errors++;
      $display("FAIL rd_written got rv=%b rdata=%h err=%b lat=%0d want 0100 12345678 0 2", v, d, e, n);
    end
    issue(3, 1'b0, 8'h20, 32'h0);
    wait_rsp(v, d, e, n);
    vectors++;
    if (v !== 4'b1000 || d !== 32'hcacacaca || e !== 1'b0) begin
      errors++;
      $display("FAIL rd_unwritten got rv=%b rdata=%h err=%b want 1000 cacacaca 0", v, d, e);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] v; logic [31:0] d; logic e; int n;
    int cnt [4] = '{0, 0, 0, 0};
    for (int i = 0; i < 4; i++) set_cmd(i, 1'b0, 8'h10, 32'h0);
    req_valid = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      logic [3:0] want;
      want = 4'b0001 << (k % 4);
      wait_rsp(v, d, e, n);
      for (int i = 0; i < 4; i++) if (v[i]) cnt[i]++;
      vectors++;
      if (v !== want || d !== 32'h12345678) begin
        errors++;
        $display("FAIL rr_order xfer %0d got rv=%b rdata=%h want %b 12345678", k, v, d, want);
      end
    end
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (cnt[i] !== 4) begin errors++; $display("FAIL rr_count req%0d got %0d want 4", i, cnt[i]); end
    end
  endtask

  task automatic test_wait_states();
    wait_states = 3;
    issue(1, 1'b1, 8'h30, 32'ha5a50001);
    vectors++;
    if ({psel, penable} !== 2'b10) begin errors++; $display("FAIL ws_setup got %b want 10", {psel, penable}); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if ({psel, penable, pwrite} !== 3'b111 || paddr !== 8'h30 || pwdata !== 32'ha5a50001 || rsp_valid !== '0) begin
        errors++;
        $display("FAIL ws_stable cyc %0d got sel/en/wr=%b addr=%h wdata=%h rv=%b want 111 30 a5a50001 0000",
                 c, {psel, penable, pwrite}, paddr, pwdata, rsp_valid);
      end
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 4'b0010 || rsp_rdata !== '0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL ws_resp got rv=%b rdata=%h err=%b want 0010 0 0", rsp_valid, rsp_rdata, rsp_err);
    end
    wait_states = 0;
  endtask

  task automatic test_timeout();
    logic [3:0] v; logic [31:0] d; logic e; int n;
    int acc = 0;
    bit got = 0;
    slave_en = 1'b0;
    issue(2, 1'b0, 8'h10, 32'h0);
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (psel && penable) acc++;
      if (rsp_valid != '0) got = 1;
    end
    vectors++;
    if (!got || acc !== 16 || rsp_valid !== 4'b0100 || rsp_err !== 1'b1 || rsp_rdata !== '0) begin
      errors++;
      $display("FAIL timeout got access=%0d rv=%b err=%b rdata=%h want 16 0100 1 0", acc, rsp_valid, rsp_err, rsp_rdata);
    end
    slave_en = 1'b1;
    issue(0, 1'b0, 8'h10, 32'h0);
    wait_rsp(v, d, e, n);
    vectors++;
    if (v !== 4'b0001 || d !== 32'h12345678 || e !== 1'b0) begin
      errors++;
      $display("FAIL after_timeout got rv=%b rdata=%h err=%b want 0001 12345678 0", v, d, e);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [3:0] v; logic [31:0] d; logic e; int n;
    slave_en = 1'b0;
    issue(1, 1'b1, 8'h40, 32'hdeadbeef);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({psel, penable} !== 2'b00 || rsp_valid !== '0) begin
      errors++;
      $display("FAIL rst_abort got sel/en=%b rv=%b want 00 0000", {psel, penable}, rsp_valid);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_cmd(i, 1'b0, 8'h10, 32'h0);
    req_valid = 4'b1111;
    slave_en = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_ptr got rdy=%b want 0001", req_ready); end
    wait_rsp(v, d, e, n);
    req_valid = '0;
    vectors++;
    if (v !== 4'b0001 || d !== 32'h12345678 || n !== 3) begin
      errors++;
      $display("FAIL rst_next got rv=%b rdata=%h lat=%0d want 0001 12345678 3", v, d, n);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = '0; written[i] = 1'b0; end
    test_reset();
    test_single_write();
    test_read_after_write();
    test_fairness();
    test_wait_states();
    test_timeout();
    test_reset_mid_access();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_rr_master_arb.md
Name: apb_rr_master_arb

Overview:
Round-robin arbiter and APB master sequencer that lets NUM_REQ local requesters share one APB bus to the apb_slave memory block.
- Each requester presents a single read or write command.
- The block grants one requester at a time and runs a full IDLE->SETUP->ACCESS APB transfer for it, waiting on pready with a timeout.
- It returns read data or an error to the winning requester only.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 8, APB address width
DATA_W, 32, APB data width
TIMEOUT, 16, max ACCESS cycles waiting for pready before abort (>=2)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
req_valid  in  NUM_REQ  per-requester command valid
req_write  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_ready  out  NUM_REQ  one-hot command accept
rsp_valid  out  NUM_REQ  one-hot response strobe, 1 cycle
rsp_rdata  out  DATA_W  read data, valid with rsp_valid
rsp_err  out  1  timeout flag, valid with rsp_valid
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  ADDR_W  APB address
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
pready  in  1  APB ready
prdata  in  DATA_W  APB read data

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has top priority first.
  - Timeout counter is 0.
- States: IDLE, SETUP, ACCESS, RESP. psel, penable and rsp_* are decoded from registered state and latched fields (Moore outputs).
- IDLE:
  - If any req_valid is high, the winner is the first set bit searching upward from last_grant+1, with modulo wrap.
  - req_ready[winner]=1 combinationally in this cycle only. The handshake is valid&&ready.
  - On the edge: latch addr, write and wdata of the winner; store grant index; last_grant<=winner; go to SETUP.
  - No valid: stay in IDLE and hold the pointer.
- SETUP (1 cycle): psel=1, penable=0, paddr/pwrite/pwdata = latched values. Next state is ACCESS; the timeout counter is cleared.
- ACCESS: psel=1, penable=1, address and control held stable.
  - pready=1 at the edge: capture prdata if read, else 0; err=0; go to RESP.
  - pready=0: increment the counter. When the counter reaches TIMEOUT-1 with no pready, go to RESP with err=1 and rdata=0.
- RESP (1 cycle):
  - psel=0, penable=0.
  - rsp_valid[grant]=1, rsp_rdata and rsp_err driven.
  - Next state is IDLE.
- Minimum transfer is 4 cycles (IDLE handshake, SETUP, ACCESS, RESP). Back-to-back transfers always pass through IDLE.
- Write transfers return rsp_valid with rsp_rdata=0.
- req_valid changes while a requester is not granted are ignored. A requester may drop valid without penalty.
- Only one transfer is ever outstanding, and req_ready is never asserted outside IDLE.
- Simultaneous requests are served in round-robin order. No requester waits more than NUM_REQ-1 grants.
- pready seen in SETUP or IDLE is ignored.
- Reset asserted in any state:
  - On the next edge, all outputs return to 0, state returns to IDLE and the pointer returns to NUM_REQ-1.
  - No rsp_valid is issued for the aborted transfer.

Test Plan:
- Single write: req0 write addr 0x10 data 0x12345678, slave pready in the first ACCESS cycle -> req_ready[0] in cycle 0; psel=1/penable=0 in cycle 1; psel=penable=1 with paddr=0x10, pwdata=0x12345678 in cycle 2; rsp_valid=0001, rsp_err=0 in cycle 3.
- Read after write: req2 reads 0x10 after the above -> rsp_valid=0100, rsp_rdata=0x12345678. Unwritten addr 0x20 -> rsp_rdata=0xcacacaca.
- Fairness: req0..req3 all held valid for 16 transfers -> grant order 0,1,2,3,0,1,2,3,...; each requester gets exactly 4 rsp_valid pulses.
- Wait states: pready held low for 3 ACCESS cycles -> paddr/pwdata/psel/penable stable throughout; rsp_valid exactly one cycle after the pready edge.
- Timeout: pready tied 0 with TIMEOUT=16 -> ACCESS lasts 16 cycles; rsp_err=1, rsp_rdata=0; the bus returns to idle and the next request is granted normally.
- Reset mid-ACCESS: reset asserted on the 2nd ACCESS cycle -> psel/penable=0 on the next edge, no rsp_valid, and the next arbitration is won by req0 when all requesters are valid.
